// File: rtl/aho_pkg.sv
// -----------------------------------------------------------------------------
// aho_pkg
// Shared definitions for the AHO receive checker.
//   aho_state_e : checker state (IDLE, RUN, FAIL)
//   MOD3/5/7    : divisors used by the multiple-flag generator
//   DEF_IDX_W   : default width of the sample index
// -----------------------------------------------------------------------------
package aho_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FAIL = 2'd2
    } aho_state_e;

    localparam int MOD3      = 3;
    localparam int MOD5      = 5;
    localparam int MOD7      = 7;
    localparam int DEF_IDX_W = 16;

endpackage

// File: rtl/aho_mod_cnt.sv
// -----------------------------------------------------------------------------
// aho_mod_cnt
// Residue counter for n mod M.  It tracks the residue of the sample index
// incrementally, so no divider is needed.
// Ports:
//   clk  in  clock
//   rst  in  synchronous active-high reset (residue -> 0)
//   clr  in  synchronous clear (residue -> 0), used for restart and index wrap
//   inc  in  advance the residue by one, wrapping M-1 -> 0
//   zero out residue == 0
// -----------------------------------------------------------------------------
module aho_mod_cnt
    import aho_pkg::*;
#(
    parameter int M = MOD3
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic zero
);

    localparam int W = (M > 1) ? $clog2(M) : 1;

    logic [W-1:0] res;

    // NOTE: sequential state is written only with non-blocking assignments, so
    // every register samples values from before the edge, whatever the order.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            res <= '0;
        end else if (inc) begin
            res <= (res == W'(M - 1)) ? '0 : res + 1'b1;
        end
    end

    assign zero = (res == '0);

endmodule

// File: rtl/aho_rx.sv
// -----------------------------------------------------------------------------
// aho_rx
// Receive-side checker for the AHO strobe stream.  It keeps its own sample
// index and mod-3/5/7 residues, predicts each AHO bit and compares it with
// the received bit.  It reports the reason bits, match/miss pulses and a
// saturating miss count, and it declares FAIL after ERR_LIMIT consecutive misses.
//
// Optional feature (macro AHO_RX_HIT_CNT_EN): adds HIT_CNT_O, a saturating
// count of matched samples whose received bit was 1.
//
// Ports:
//   CLK        in   clock
//   RST        in   synchronous active-high reset
//   START      in   restart checking at index 0 (takes priority over VALID)
//   VALID      in   AHO_IN carries a sample this cycle
//   AHO_IN     in   received AHO bit
//   IDX_O      out  index of the last checked sample
//   WHY_O      out  {div7,div5,div3} of the last checked index
//   MATCH_O    out  one-cycle pulse, sample matched prediction
//   MISS_O     out  one-cycle pulse, sample mismatched
//   ERR_CNT_O  out  total misses since START, saturating
//   RUN_O      out  state == RUN
//   FAIL_O     out  state == FAIL (sticky until START/RST)
//   HIT_CNT_O  out  matched '1' samples, saturating (AHO_RX_HIT_CNT_EN only)
// -----------------------------------------------------------------------------
module aho_rx
    import aho_pkg::*;
#(
    parameter int IDX_W     = DEF_IDX_W,
    parameter int ERR_LIMIT = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic                 VALID,
    input  logic                 AHO_IN,
    output logic [IDX_W-1:0]     IDX_O,
    output logic [2:0]           WHY_O,
    output logic                 MATCH_O,
    output logic                 MISS_O,
    output logic [ERR_CNT_W-1:0] ERR_CNT_O,
    output logic                 RUN_O,
    output logic                 FAIL_O
`ifdef AHO_RX_HIT_CNT_EN
    ,
    output logic [IDX_W-1:0]     HIT_CNT_O
`endif
);

    // ERR_LIMIT is at most 255, so an 8-bit consecutive-miss counter suffices.
    localparam int CONSEC_W = 8;

    aho_state_e          state_q;
    aho_state_e          state_d;
    logic [IDX_W-1:0]    idx;
    logic [CONSEC_W-1:0] consec;
    logic [CONSEC_W-1:0] consec_nxt;
    logic                z3, z5, z7;
    logic                check;
    logic                idx_wrap;
    logic [2:0]          why;
    logic                pred;
    logic                hit;
    logic                fail_now;

    // A sample is compared only in RUN; START in the same cycle wins.
    assign check    = VALID && !START && (state_q == RUN);
    assign idx_wrap = (idx == '1);

    // Index 0 never fires, even though every residue is 0 there.
    assign why  = (idx == '0) ? 3'b000 : {z7, z5, z3};
    assign pred = |why;
    assign hit  = (AHO_IN == pred);

    assign consec_nxt = consec + 1'b1;
    assign fail_now   = check && !hit && (consec_nxt == CONSEC_W'(ERR_LIMIT));

    // At the top index the generator clears index and residues together, so
    // the residues restart at 0 instead of continuing modulo M.
    aho_mod_cnt #(.M(MOD3)) u_mod3 (
        .clk  (CLK),
        .rst  (RST),
        .clr  (START || (check && idx_wrap)),
        .inc  (check && !idx_wrap),
        .zero (z3)
    );

    aho_mod_cnt #(.M(MOD5)) u_mod5 (
        .clk  (CLK),
        .rst  (RST),
        .clr  (START || (check && idx_wrap)),
        .inc  (check && !idx_wrap),
        .zero (z5)
    );

    aho_mod_cnt #(.M(MOD7)) u_mod7 (
        .clk  (CLK),
        .rst  (RST),
        .clr  (START || (check && idx_wrap)),
        .inc  (check && !idx_wrap),
        .zero (z7)
    );

    // NOTE: the next state gets a default before the case, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (START) state_d = RUN;
            RUN: begin
                if (START)         state_d = RUN;
                else if (fail_now) state_d = FAIL;
            end
            FAIL: if (START) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            idx       <= '0;
            consec    <= '0;
            IDX_O     <= '0;
            WHY_O     <= '0;
            MATCH_O   <= 1'b0;
            MISS_O    <= 1'b0;
            ERR_CNT_O <= '0;
            RUN_O     <= 1'b0;
            FAIL_O    <= 1'b0;
        end else begin
            state_q <= state_d;
            RUN_O   <= (state_d == RUN);
            FAIL_O  <= (state_d == FAIL);
            MATCH_O <= check && hit;
            MISS_O  <= check && !hit;

            if (START) begin
                idx       <= '0;
                consec    <= '0;
                ERR_CNT_O <= '0;
            end else if (check) begin
                IDX_O <= idx;
                WHY_O <= why;
                idx   <= idx_wrap ? '0 : idx + 1'b1;
                if (hit) begin
                    consec <= '0;
                end else begin
                    consec <= consec_nxt;
                    if (ERR_CNT_O != '1) ERR_CNT_O <= ERR_CNT_O + 1'b1;
                end
            end
        end
    end

`ifdef AHO_RX_HIT_CNT_EN
    always_ff @(posedge CLK) begin
        if (RST || START) begin
            HIT_CNT_O <= '0;
        end else if (check && hit && AHO_IN && (HIT_CNT_O != '1)) begin
            HIT_CNT_O <= HIT_CNT_O + 1'b1;
        end
    end
`endif

endmodule
